// File: rtl/bsg_axis_packet_arbiter.sv
// Packet-atomic round-robin AXI-Stream arbiter feeding a 2-entry registered FIFO.
// Optional stall-timeout detector enabled by defining BSG_AXIS_ARB_TIMEOUT_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_axis_packet_arbiter #(
  parameter int num_in_p     = 2,
  parameter int data_width_p = 64,
  parameter int timeout_p    = 1024,
  localparam int lg_in_lp    = `BSG_SAFE_CLOG2(num_in_p),
  localparam int keep_w_lp   = data_width_p / 8
) (
  input  logic                              aclk_i,
  input  logic                              areset_i,
  input  logic [num_in_p-1:0]               s_tvalid_i,
  output logic [num_in_p-1:0]               s_tready_o,
  input  logic [num_in_p*data_width_p-1:0]  s_tdata_i,
  input  logic [num_in_p*keep_w_lp-1:0]     s_tkeep_i,
  input  logic [num_in_p-1:0]               s_tlast_i,
  output logic                              m_tvalid_o,
  input  logic                              m_tready_i,
  output logic [data_width_p-1:0]           m_tdata_o,
  output logic [keep_w_lp-1:0]              m_tkeep_o,
  output logic                              m_tlast_o,
  output logic [lg_in_lp-1:0]               m_tid_o,
  output logic                              error_o
);

  typedef struct packed {
    logic [data_width_p-1:0] data;
    logic [keep_w_lp-1:0]    keep;
    logic                    last;
    logic [lg_in_lp-1:0]     id;
  } beat_s;

  typedef enum logic {eIDLE, eLOCKED} state_e;

  logic [num_in_p-1:0][data_width_p-1:0] s_data;
  logic [num_in_p-1:0][keep_w_lp-1:0]    s_keep;

  for (genvar i = 0; i < num_in_p; i++) begin : g_unpack
    assign s_data[i] = s_tdata_i[i*data_width_p +: data_width_p];
    assign s_keep[i] = s_tkeep_i[i*keep_w_lp +: keep_w_lp];
  end

  // (a + b) mod num_in_p, valid for a, b < num_in_p
  function automatic logic [lg_in_lp-1:0] add_mod(input logic [lg_in_lp-1:0] a, input int b);
    logic [lg_in_lp:0] s;
    s = {1'b0, a} + (lg_in_lp+1)'(b);
    if (s >= (lg_in_lp+1)'(num_in_p)) s = s - (lg_in_lp+1)'(num_in_p);
    return s[lg_in_lp-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [lg_in_lp-1:0] rr_q, rr_d, grant_q, grant_d;
  logic [lg_in_lp-1:0] cand, sel;
  logic                cand_v, sel_v, enq, deq, sel_last;

  logic [1:0] count_q, count_d;
  logic       space_q, space_d;
  beat_s      head_q, head_d, tail_q, tail_d, in_beat;

  always_comb begin
    cand   = rr_q;
    cand_v = 1'b0;
    for (int k = 0; k < num_in_p; k++) begin
      if (!cand_v && s_tvalid_i[add_mod(rr_q, k)]) begin
        cand   = add_mod(rr_q, k);
        cand_v = 1'b1;
      end
    end
  end

  assign sel      = (state_q == eLOCKED) ? grant_q : cand;
  assign sel_v    = (state_q == eLOCKED) | cand_v;
  assign sel_last = s_tlast_i[sel];
  assign enq      = space_q & sel_v & s_tvalid_i[sel];
  assign deq      = (count_q != 2'd0) & m_tready_i;

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q <= eIDLE;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    case (state_q)
      eIDLE: if (enq) begin
        if (sel_last) rr_d = add_mod(cand, 1);
        else begin
          grant_d = cand;
          state_d = eLOCKED;
        end
      end
      eLOCKED: if (enq && sel_last) begin
        state_d = eIDLE;
        rr_d    = add_mod(grant_q, 1);
      end
      default: state_d = eIDLE;
    endcase
  end

  // Readiness depends only on registered space, never on m_tready_i.
  always_comb begin
    s_tready_o = '0;
    if (sel_v && space_q) s_tready_o[sel] = 1'b1;
  end

  assign in_beat = '{data: s_data[sel], keep: s_keep[sel], last: sel_last, id: sel};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {1'b0, enq} - {1'b0, deq};
    case (count_q)
      2'd0: if (enq) head_d = in_beat;
      2'd1: begin
        if (enq && deq) head_d = in_beat;
        else if (enq)   tail_d = in_beat;
      end
      default: if (deq) begin
        head_d = tail_q;
        if (enq) tail_d = in_beat;
      end
    endcase
    space_d = (count_d < 2'd2);
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      count_q <= '0;
      space_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      space_q <= space_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign m_tvalid_o = (count_q != 2'd0);
  assign m_tdata_o  = head_q.data;
  assign m_tkeep_o  = head_q.keep;
  assign m_tlast_o  = head_q.last;
  assign m_tid_o    = head_q.id;

`ifdef BSG_AXIS_ARB_TIMEOUT_EN
  localparam int cnt_w_lp = $clog2(timeout_p + 1);
  logic [cnt_w_lp-1:0] tcnt_q, tcnt_d;
  logic                err_q;

  // Saturates at the limit so the flag cannot be missed by wrap-around.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q != eLOCKED || enq) tcnt_d = '0;
    else if (!s_tvalid_i[grant_q] && tcnt_q != cnt_w_lp'(timeout_p)) tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_q | (tcnt_q == cnt_w_lp'(timeout_p));
    end
  end

  assign error_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (timeout_p == 0);
  assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_axis_packet_arbiter.sv
// Randomized + directed bench for bsg_axis_packet_arbiter against a queue-based
// reference model of the arbitration and FIFO rules.
module tb_bsg_axis_packet_arbiter;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int KW = W / 8;
  localparam int LG = 2;
  localparam int TO = 8;

  logic          aclk = 1'b0, areset;
  logic [N-1:0]  s_tvalid, s_tready, s_tlast;
  logic [N*W-1:0]  s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic          m_tvalid, m_tready, m_tlast, error;
  logic [W-1:0]  m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [LG-1:0] m_tid;

  bsg_axis_packet_arbiter #(.num_in_p(N), .data_width_p(W), .timeout_p(TO)) dut (
    .aclk_i(aclk), .areset_i(areset),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
    .s_tkeep_i(s_tkeep), .s_tlast_i(s_tlast),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata),
    .m_tkeep_o(m_tkeep), .m_tlast_o(m_tlast), .m_tid_o(m_tid), .error_o(error));

  always #5 aclk = ~aclk;

  int vectors = 0, errors = 0, cyc = 0;

  typedef struct { logic [W-1:0] d; logic [KW-1:0] k; logic l; int id; } beat_t;
  beat_t q[$];
  bit mlock, mspace;
  int mown, mrr;

  bit ven[N], rndlen;
  int seq[N], bidx[N], plen[N], pkts[N];
  logic [KW-1:0] gk[N];
  int obs_id[$], obs_cyc[$];
  logic [W-1:0] obs_d[$];
  logic [N-1:0] samp_rdy;
`ifdef BSG_AXIS_ARB_TIMEOUT_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]           = ven[i] && pkts[i] > 0;
      s_tdata[i*W +: W]     = W'(i * (1 << 24) + seq[i]);
      s_tkeep[i*KW +: KW]   = gk[i];
      s_tlast[i]            = (bidx[i] == plen[i] - 1);
    end
  endtask

  task automatic setgen(input int i, input int len, input int np, input int s0);
    plen[i] = len; pkts[i] = np; seq[i] = s0; bidx[i] = 0; gk[i] = KW'($urandom);
  endtask

  task automatic mreset();
    q.delete(); obs_id.delete(); obs_d.delete(); obs_cyc.delete();
    mlock = 0; mrr = 0; mspace = 0; rndlen = 0;
    for (int i = 0; i < N; i++) begin ven[i] = 0; bidx[i] = 0; pkts[i] = 0; end
  endtask

  task automatic advance(input int i);
    seq[i]++; gk[i] = KW'($urandom);
    if (bidx[i] == plen[i] - 1) begin
      bidx[i] = 0; pkts[i]--;
      if (rndlen) plen[i] = $urandom_range(1, 4);
    end else bidx[i]++;
  endtask

  // One clock: check DUT against model at negedge, advance model, drive next inputs.
  task automatic cycle();
    int sel; logic [N-1:0] er; beat_t b;
    @(negedge aclk); cyc++;
    sel = -1; er = '0;
    if (mspace) begin
      if (mlock) sel = mown;
      else for (int k = 0; k < N; k++) if (sel < 0 && s_tvalid[(mrr + k) % N]) sel = (mrr + k) % N;
      if (sel >= 0) er[sel] = 1'b1;
    end
    samp_rdy = s_tready;
    vectors++;
    if (s_tready !== er) begin errors++; $display("FAIL s_tready got %b exp %b cyc %0d", s_tready, er, cyc); end
    vectors++;
    if (m_tvalid !== (q.size() != 0)) begin errors++; $display("FAIL m_tvalid got %b exp %0d cyc %0d", m_tvalid, q.size() != 0, cyc); end
    if (q.size() != 0) begin
      vectors++;
      if ({m_tdata, m_tkeep, m_tlast, m_tid} !== {q[0].d, q[0].k, q[0].l, LG'(q[0].id)}) begin
        errors++;
        $display("FAIL m_beat got d=%h k=%h l=%b id=%0d exp d=%h k=%h l=%b id=%0d cyc %0d",
                 m_tdata, m_tkeep, m_tlast, m_tid, q[0].d, q[0].k, q[0].l, q[0].id, cyc);
      end
    end
`ifndef BSG_AXIS_ARB_TIMEOUT_EN
    vectors++;
    if (error !== 1'b0) begin errors++; $display("FAIL error_o got %b exp 0 cyc %0d", error, cyc); end
`endif
    if (m_tvalid && m_tready) begin obs_id.push_back(int'(m_tid)); obs_d.push_back(m_tdata); obs_cyc.push_back(cyc); end
    if (q.size() != 0 && m_tready) void'(q.pop_front());
    if (sel >= 0 && s_tvalid[sel]) begin
      b.d = s_tdata[sel*W +: W]; b.k = s_tkeep[sel*KW +: KW]; b.l = s_tlast[sel]; b.id = sel;
      q.push_back(b);
      if (b.l) begin mlock = 0; mrr = (sel + 1) % N; end
      else begin mlock = 1; mown = sel; end
      advance(sel);
    end
    mspace = (q.size() < 2);
    @(posedge aclk); #1; drive();
  endtask

  task automatic do_reset();
    areset = 1'b1; @(posedge aclk); #1; areset = 1'b0;
    mreset(); drive();
  endtask

  task automatic test_reset();
    mreset(); areset = 1'b1; ven[0] = 1; ven[1] = 1; setgen(0, 1, 1, 1); setgen(1, 1, 1, 2); drive();
    #22;
    vectors++;
    if ({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, error} !== '0) begin
      errors++; $display("FAIL reset_outputs got rdy=%b v=%b d=%h k=%h l=%b id=%0d e=%b exp all 0",
                         s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, error);
    end
    @(posedge aclk); #1; areset = 1'b0; mreset(); drive();
  endtask

  task automatic test_two_single();
    do_reset(); m_tready = 1;
    setgen(0, 1, 1, 16'h10); setgen(1, 1, 1, 16'h11); ven[0] = 1; ven[1] = 1; drive();
    for (int c = 0; c < 8; c++) cycle();
    vectors++;
    if (obs_id.size() != 2 || obs_id[0] != 0 || obs_id[1] != 1 || obs_cyc[1] != obs_cyc[0] + 1) begin
      errors++; $display("FAIL two_single got %0d beats ids %p exp ids 0,1 consecutive", obs_id.size(), obs_id);
    end
  endtask

  task automatic test_packet_lock();
    int exp_ids[5] = '{0, 0, 0, 0, 1};
    do_reset(); m_tready = 1;
    setgen(0, 4, 1, 16'h20); setgen(1, 1, 1, 16'h28); ven[0] = 1; drive();
    for (int c = 0; c < 20 && bidx[0] != 1; c++) cycle();
    ven[1] = 1; drive();
    for (int c = 0; c < 12; c++) cycle();
    vectors++;
    if (obs_id.size() != 5) begin errors++; $display("FAIL packet_lock got %0d beats exp 5", obs_id.size()); end
    else for (int j = 0; j < 5; j++) begin
      vectors++;
      if (obs_id[j] != exp_ids[j]) begin errors++; $display("FAIL packet_lock beat %0d got tid %0d exp %0d", j, obs_id[j], exp_ids[j]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); m_tready = 1;
    for (int i = 0; i < N; i++) begin setgen(i, 1, 2, 16'h30 + i); ven[i] = 1; end
    drive();
    for (int c = 0; c < 12; c++) cycle();
    vectors++;
    if (obs_id.size() != 6) begin errors++; $display("FAIL back_to_back got %0d beats exp 6", obs_id.size()); end
    else for (int j = 0; j < 6; j++) begin
      vectors++;
      if (obs_id[j] != j % 3 || obs_cyc[j] != obs_cyc[0] + j) begin
        errors++; $display("FAIL back_to_back beat %0d got tid %0d cyc %0d exp tid %0d cyc %0d", j, obs_id[j], obs_cyc[j], j % 3, obs_cyc[0] + j);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(); m_tready = 0;
    setgen(0, 1, 6, 8'hA0); ven[0] = 1; drive();
    for (int c = 0; c < 10; c++) cycle();
    vectors++;
    if (samp_rdy !== '0 || m_tvalid !== 1'b1) begin errors++; $display("FAIL backpressure_full got rdy=%b v=%b exp rdy=000 v=1", samp_rdy, m_tvalid); end
    m_tready = 1;
    for (int c = 0; c < 15; c++) cycle();
    vectors++;
    if (obs_d.size() != 6) begin errors++; $display("FAIL backpressure got %0d beats exp 6", obs_d.size()); end
    else for (int j = 0; j < 6; j++) begin
      vectors++;
      if (obs_d[j][7:0] !== 8'(8'hA0 + j)) begin errors++; $display("FAIL backpressure beat %0d got %h exp %h", j, obs_d[j][7:0], 8'(8'hA0 + j)); end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset(); m_tready = 0;
    setgen(0, 4, 1, 16'h50); ven[0] = 1; drive();
    for (int c = 0; c < 20 && bidx[0] != 2; c++) cycle();
    vectors++;
    if (bidx[0] != 2) begin errors++; $display("FAIL reset_mid_setup got beat %0d exp 2", bidx[0]); end
    areset = 1'b1; #1;
    vectors++;
    if ({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, error} !== '0) begin
      errors++; $display("FAIL reset_mid got rdy=%b v=%b d=%h k=%h l=%b id=%0d e=%b exp all 0",
                         s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, error);
    end
    #1; areset = 1'b0; mreset(); m_tready = 1;
    setgen(1, 1, 1, 16'h60); setgen(2, 1, 1, 16'h70); ven[1] = 1; ven[2] = 1; drive();
    for (int c = 0; c < 8; c++) cycle();
    vectors++;
    if (obs_id.size() != 2 || obs_id[0] != 1 || obs_id[1] != 2) begin
      errors++; $display("FAIL reset_mid_next got ids %p exp 1,2", obs_id);
    end
  endtask

  task automatic test_timeout();
    do_reset(); m_tready = 1;
    setgen(0, 3, 1, 16'h80); ven[0] = 1; drive();
    for (int c = 0; c < 20 && bidx[0] != 1; c++) cycle();
    ven[0] = 0; drive();
    for (int c = 0; c < 4; c++) cycle();
    vectors++;
    if (error !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", error); end
    for (int c = 0; c < 10; c++) cycle();
    vectors++;
    if (error !== EXP_ERR) begin errors++; $display("FAIL timeout_set got %b exp %b", error, EXP_ERR); end
    ven[0] = 1; drive();
    for (int c = 0; c < 6; c++) cycle();
    vectors++;
    if (error !== EXP_ERR || obs_id.size() != 3) begin
      errors++; $display("FAIL timeout_sticky got err %b beats %0d exp err %b beats 3", error, obs_id.size(), EXP_ERR);
    end
  endtask

  task automatic test_random();
    do_reset(); rndlen = 1;
    for (int i = 0; i < N; i++) setgen(i, $urandom_range(1, 4), 100000, i * 4096);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) ven[i] = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 9) < 7);
      drive();
      cycle();
    end
  endtask

  initial begin
    m_tready = 1'b0; areset = 1'b1;
    test_reset();
    test_two_single();
    test_packet_lock();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
